// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ready;

    logic              bus_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // master: the arbiter itself (serves both requesters, drives the memory)
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // slave: the core ports plus the memory model around the arbiter
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported variable-latency memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;
    logic              fetch_starved;

    assign fetch_starved = bus.if_req && (streak_q == STREAK_MAX);

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (bus.d_req && !fetch_starved) begin
                    state_d     = MEM_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    if (!bus.if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (bus.if_req) begin
                    state_d    = MEM_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    streak_d   = '0;
                end
            end

            MEM_I, MEM_D: begin
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    if (state_q == MEM_I) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // the memory never answered: complete with an error and a harmless value
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    bus_err_d = 1'b1;
                    if (state_q == MEM_I) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = NOP_INSTR;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = '0;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            RESP: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .MAX_STREAK(MAX_STREAK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] marr [logic [31:0]];

    // transaction model: one in-flight record plus the edge at which the last one ended
    int          cyc = 0;
    bit          m_busy = 1'b0;
    bit          m_fetch, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_wait;
    int          m_end = -10;
    int          m_streak = 0;
    bit          e_mem_req, e_mem_we, e_if_ready, e_d_ready, e_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

    int  rsp_delay = 0;
    bit  rsp_busy  = 1'b0;
    int  rsp_cnt   = 0;
    bit  auto_if   = 1'b0;
    bit  auto_d    = 1'b0;

    bit    prev_mem_req = 1'b0;
    int    rise_cyc[$];
    logic [31:0] rise_addr[$];
    string dut_log = "";
    int    ifready_cnt = 0;
    int    dready_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (marr.exists(a)) return marr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic model_step();
        bit take_d;
        cyc++;
        if (!reset) begin
            m_busy = 1'b0; m_streak = 0; m_end = cyc - 1;
            e_mem_req = 1'b0; e_mem_we = 1'b0; e_if_ready = 1'b0; e_d_ready = 1'b0; e_err = 1'b0;
            e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
            return;
        end
        e_if_ready = 1'b0; e_d_ready = 1'b0; e_err = 1'b0;
        if (cyc == m_end + 1) e_mem_we = 1'b0;
        if (m_busy) begin
            if (!bus.mem_ack) m_wait++;
            if (bus.mem_ack || m_wait == TIMEOUT) begin
                m_busy = 1'b0; m_end = cyc; e_mem_req = 1'b0; e_err = !bus.mem_ack;
                if (m_fetch) begin
                    e_if_ready = 1'b1;
                    e_if_rdata = bus.mem_ack ? mrd(m_addr) : 32'h0000_0013;
                end else begin
                    e_d_ready = 1'b1;
                    if (!m_we) e_d_rdata = bus.mem_ack ? mrd(m_addr) : 32'h0;
                    else if (bus.mem_ack) marr[m_addr] = m_wdata;
                end
            end
        end else if (cyc >= m_end + 2 && (bus.if_req || bus.d_req)) begin
            take_d = bus.d_req && !(bus.if_req && m_streak >= MAX_STREAK);
            m_streak = (take_d && bus.if_req) ? ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK) : 0;
            m_busy = 1'b1; m_wait = 0; m_fetch = !take_d;
            m_we = take_d && bus.d_we;
            m_addr = take_d ? bus.d_addr : bus.if_addr;
            if (take_d) m_wdata = bus.d_wdata;
            e_mem_req = 1'b1; e_mem_we = m_we; e_mem_addr = m_addr;
            if (take_d) e_mem_wdata = m_wdata;
        end
    endtask

    task automatic compare_all();
        chk1("mem_req", bus.mem_req, e_mem_req);
        chk1("mem_we", bus.mem_we, e_mem_we);
        chk("mem_addr", bus.mem_addr, e_mem_addr);
        chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
        chk1("if_ready", bus.if_ready, e_if_ready);
        chk1("d_ready", bus.d_ready, e_d_ready);
        chk1("bus_err", bus.bus_err, e_err);
        chk("if_rdata", bus.if_rdata, e_if_rdata);
        chk("d_rdata", bus.d_rdata, e_d_rdata);
    endtask

    task automatic responder();
        int r;
        if (bus.mem_ack) bus.mem_ack = 1'b0;
        if (!bus.mem_req) begin
            rsp_busy = 1'b0;
            bus.mem_rdata = $urandom;
            return;
        end
        if (!rsp_busy) begin
            rsp_busy = 1'b1;
            if (rsp_delay >= 0) rsp_cnt = rsp_delay;
            else begin
                r = int'($urandom_range(0, 15));
                rsp_cnt = (r == 0) ? 1000 : r % 4;
            end
        end
        if (rsp_cnt == 0) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = mrd(bus.mem_addr);
        end else begin
            rsp_cnt--;
            bus.mem_rdata = $urandom;
        end
    endtask

    task automatic new_fetch();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
    endtask

    task automatic new_data();
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 32'h200 + 32'(4 * $urandom_range(0, 7));
        bus.d_wdata = $urandom;
    endtask

    task automatic requesters();
        if (auto_if) begin
            if (bus.if_req && bus.if_ready) begin
                if ($urandom_range(0, 1) == 1) new_fetch(); else bus.if_req = 1'b0;
            end else if (!bus.if_req && $urandom_range(0, 2) == 0) new_fetch();
        end
        if (auto_d) begin
            if (bus.d_req && bus.d_ready) begin
                if ($urandom_range(0, 1) == 1) new_data(); else bus.d_req = 1'b0;
            end else if (!bus.d_req && $urandom_range(0, 2) == 0) new_data();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        if (bus.mem_req && !prev_mem_req) begin
            rise_cyc.push_back(cyc);
            rise_addr.push_back(bus.mem_addr);
            if (bus.mem_addr < 32'h200) dut_log = {dut_log, "I"};
            else dut_log = {dut_log, "D"};
        end
        prev_mem_req = bus.mem_req;
        if (bus.if_ready) ifready_cnt++;
        if (bus.d_ready) dready_cnt++;
        responder();
        requesters();
    endtask

    task automatic wait_ready(input bit fetch, input int budget, input string name);
        int n = 0;
        while (!(fetch ? bus.if_ready : bus.d_ready) && n < budget) begin
            tick();
            n++;
        end
        chk1(name, fetch ? bus.if_ready : bus.d_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, d0, i0, e_edge, gaps_bad;
        logic [31:0] first_addr;
        bit got;

        reset = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (3) tick();
        chk1("reset_mem_req", bus.mem_req, 1'b0);
        chk("reset_mem_addr", bus.mem_addr, 32'h0);

        // single fetch, ack in first mem_req cycle
        marr[32'h100] = 32'h0050_0093;
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        tick();
        chk1("fetch_t1_mem_req", bus.mem_req, 1'b1);
        chk("fetch_t1_mem_addr", bus.mem_addr, 32'h100);
        chk1("fetch_t1_mem_we", bus.mem_we, 1'b0);
        tick();
        chk1("fetch_t2_if_ready", bus.if_ready, 1'b1);
        chk("fetch_t2_if_rdata", bus.if_rdata, 32'h0050_0093);
        bus.if_req = 1'b0;
        tick();
        chk1("fetch_t3_if_ready", bus.if_ready, 1'b0);
        tick();

        // store then load with a 2-cycle memory
        rsp_delay = 1;
        d0 = dready_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk1("store_mem_we", bus.mem_we, 1'b1);
        chk("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        wait_ready(1'b0, 20, "store_done");
        bus.d_req = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        wait_ready(1'b0, 20, "load_done");
        chk("load_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        repeat (3) tick();
        chk("store_load_pulses", 32'(dready_cnt - d0), 32'd2);

        // contention: both held continuously
        rsp_delay = 0;
        dut_log = "";
        rise_cyc.delete();
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h240;
        repeat (33) tick();
        n = 0;
        while ((bus.if_req || bus.d_req) && n < 20) begin
            if (bus.if_ready) bus.if_req = 1'b0;
            if (bus.d_ready) bus.d_req = 1'b0;
            if (bus.if_req || bus.d_req) tick();
            n++;
        end
        chk("contention_drain", {30'd0, bus.if_req, bus.d_req}, 32'd0);
        total++;
        if (dut_log.len() < 10 || dut_log.substr(0, 9) != "DDDDIDDDDI") begin
            bad++;
            $display("FAIL contention_order: actual=%s required=DDDDIDDDDI...", dut_log);
        end
        gaps_bad = 0;
        for (int k = 1; k < 10 && k < rise_cyc.size(); k++)
            if (rise_cyc[k] - rise_cyc[k-1] != 3) gaps_bad++;
        chk("contention_gap", 32'(gaps_bad), 32'd0);
        repeat (3) tick();

        // data load timeout
        rsp_delay = 1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        n = 0; cnt = 0;
        while (!bus.d_ready && n < 30) begin
            tick();
            n++;
            if (bus.mem_req) cnt++;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'd8);
        chk1("tmo_d_ready", bus.d_ready, 1'b1);
        chk1("tmo_bus_err", bus.bus_err, 1'b1);
        chk("tmo_d_rdata", bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
        tick();
        chk1("tmo_err_clear", bus.bus_err, 1'b0);

        // fetch timeout
        bus.if_req = 1'b1; bus.if_addr = 32'h1F0;
        wait_ready(1'b1, 30, "tmo_fetch_done");
        chk("tmo_if_rdata", bus.if_rdata, 32'h0000_0013);
        chk1("tmo_fetch_err", bus.bus_err, 1'b1);
        bus.if_req = 1'b0;
        repeat (2) tick();

        // reset in the middle of a data transaction
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h204;
        repeat (3) tick();
        chk1("rst_mid_mem_req_before", bus.mem_req, 1'b1);
        reset = 1'b0;
        bus.d_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h140;
        tick();
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_d_ready", bus.d_ready, 1'b0);
        chk1("rst_if_ready", bus.if_ready, 1'b0);
        reset = 1'b1;
        rsp_delay = 0;
        marr[32'h140] = 32'h1234_5678;
        d0 = dready_cnt; i0 = ifready_cnt; got = 1'b0; first_addr = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.mem_req && !got) begin first_addr = bus.mem_addr; got = 1'b1; end
            if (bus.if_ready) bus.if_req = 1'b0;
        end
        chk("rst_regrant_addr", first_addr, 32'h140);
        chk("rst_no_stale_dready", 32'(dready_cnt - d0), 32'd0);
        chk("rst_fetch_done", 32'(ifready_cnt - i0), 32'd1);

        // back-to-back fetch with a new address across if_ready
        rise_cyc.delete(); rise_addr.delete();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        e_edge = -1; i0 = ifready_cnt;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.if_ready) begin
                if (ifready_cnt - i0 == 1) begin e_edge = cyc; bus.if_addr = 32'h104; end
                else bus.if_req = 1'b0;
            end
        end
        chk("b2b_grants", 32'(rise_cyc.size()), 32'd2);
        if (rise_cyc.size() >= 2) begin
            chk("b2b_second_edge", 32'(rise_cyc[1]), 32'(e_edge + 2));
            chk("b2b_second_addr", rise_addr[1], 32'h104);
        end
        bus.if_req = 1'b0;
        repeat (3) tick();

        // randomized traffic, with one reset in the middle
        rsp_delay = -1;
        auto_if = 1'b1; auto_d = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            reset = (k == 1500) ? 1'b0 : 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the core's instruction-fetch port and its data (load/store) port.
- Grants at most one transaction at a time, with data-over-fetch priority and a starvation guard for fetch.
- Handles the memory handshake and a timeout, and returns a one-cycle ready/err pulse to the winning requester.
- Sits between the rv32 core's pc/instr and aluout/writedata/readdata/writesmem ports and the memory model.

Parameters:
- ADDR_W, 32, address width.
- MAX_STREAK, 4, max consecutive data grants while fetch is pending (must be ≥1).
- TIMEOUT, 255, cycles of mem_req without mem_ack before abort (must be ≥1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  32  fetched instruction, valid when if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid when d_ready
- d_ready  out  1  one-cycle data completion pulse
- bus_err  out  1  pulses with if_ready/d_ready when the transaction timed out
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only while mem_req=1

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge), from any state including mid-transaction:
  - state=IDLE;
  - mem_req, mem_we, if_ready, d_ready and bus_err = 0;
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0;
  - streak and timeout counters = 0;
  - any in-flight transaction is abandoned and no ready is issued for it.
- FSM states: IDLE, MEM_I, MEM_D, RESP.
- IDLE, arbitration evaluated every cycle:
  - Grant data if d_req=1, unless if_req=1 and streak==MAX_STREAK, in which case grant fetch.
  - Otherwise grant fetch if if_req=1.
  - Otherwise stay in IDLE.
- On a grant, latch the address/data at that edge and enter MEM_I or MEM_D; mem_req=1 from the next cycle.
  - Fetch grant: mem_we=0.
  - Data grant: mem_we=d_we, mem_wdata=d_wdata.
- Streak counter:
  - Data grant with if_req=1: streak+1, saturating at MAX_STREAK.
  - Fetch grant, or any grant with if_req=0: streak=0.
- MEM_I / MEM_D:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - Requester inputs are ignored (requesters must keep them stable anyway).
  - Timeout counter increments each cycle mem_ack=0.
- mem_ack=1 at an edge in MEM_x:
  - capture mem_rdata into the matching if_rdata/d_rdata (stores leave d_rdata unchanged);
  - mem_req→0, enter RESP, pulse x_ready=1 for exactly that RESP cycle;
  - timeout counter → 0.
- Timeout counter reaching TIMEOUT while still in MEM_x:
  - abort with mem_req→0, enter RESP;
  - x_ready=1 and bus_err=1 for one cycle;
  - rdata forced to 32'h00000013 (NOP) for fetch, 0 for load.
- RESP: x_ready, bus_err, mem_we → 0 next; always → IDLE. No grant is made in RESP, so a requester sees its ready before it re-arbitrates.
- Latency:
  - Request visible in IDLE at edge t0 → mem_req high t0+1.
  - mem_ack sampled at edge tk → ready high during cycle tk+1.
  - Next grant possible at edge tk+2.
  - Minimum is 3 cycles per transaction (ack in first mem_req cycle).
- Simultaneous if_req and d_req: data wins except under the starvation rule above.
- A request dropped by a requester before its ready is a protocol violation; behaviour is undefined (the bench should flag it).

Test Plan:
- Single fetch: reset released, if_req=1, if_addr=0x100, mem_ack high in first mem_req cycle with mem_rdata=0x00500093 → mem_req=1/mem_addr=0x100/mem_we=0 at t1; if_ready=1, if_rdata=0x00500093 at t2; if_ready=0 at t3.
- Store/load: d_req store d_addr=0x200, d_wdata=0xDEADBEEF, then load from 0x200, mem model 2-cycle ack → mem_we=1 with wdata=0xDEADBEEF on the store; on the load, d_rdata=0xDEADBEEF with d_ready, and d_ready pulses exactly once per transaction.
- Contention: if_req and d_req both held continuously, MAX_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I…; no gap beyond the 3-cycle transaction period.
- Timeout: TIMEOUT=8, data load with mem_ack never asserted → mem_req high exactly 8 cycles, then d_ready=1, bus_err=1, d_rdata=0; fetch timeout yields if_rdata=0x00000013.
- Reset mid-transaction: reset=0 while in MEM_D with mem_req=1 → next cycle mem_req=0, all readies 0, state IDLE; after release a pending if_req is granted normally and no stale d_ready appears.
- Back-to-back fetch: if_req held high across if_ready with a new if_addr=0x104 → second grant at tk+2, mem_addr=0x104, no duplicate grant of 0x100.
